// File: rtl/rv_writeback_arbiter.sv
// Writeback arbiter: round-robin pick among execute-unit response
// channels, registered GPR write port and retire counter.
module rv_writeback_arbiter #(
   parameter int NUM_SRCS    = 3,
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2,
   parameter int NR_BITS     = 5,
   parameter int UUID_BITS   = 44
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SRCS-1:0]             valid_in,
   input  logic [NUM_SRCS*UUID_BITS-1:0]   uuid_in,
   input  logic [NUM_SRCS*NW_BITS-1:0]     wid_in,
   input  logic [NUM_SRCS*NUM_THREADS-1:0] tmask_in,
   input  logic [NUM_SRCS*32-1:0]          PC_in,
   input  logic [NUM_SRCS*NR_BITS-1:0]     rd_in,
   input  logic [NUM_SRCS-1:0]             wb_in,
   input  logic [NUM_SRCS*NUM_THREADS*32-1:0] data_in,
   output logic [NUM_SRCS-1:0]             ready_out,
   output logic                            wb_valid,
   output logic [UUID_BITS-1:0]            wb_uuid,
   output logic [NW_BITS-1:0]              wb_wid,
   output logic [NUM_THREADS-1:0]          wb_tmask,
   output logic [31:0]                     wb_PC,
   output logic [NR_BITS-1:0]              wb_rd,
   output logic [NUM_THREADS*32-1:0]       wb_data,
   output logic                            retire_valid,
   output logic [NW_BITS-1:0]              retire_wid,
   output logic [63:0]                     retire_count
);

   localparam int PW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
   localparam int DW = NUM_THREADS * 32;

   logic [PW-1:0]          ptr_q, ptr_d, gidx;
   logic                   gnt;
   logic [NUM_SRCS-1:0]    gnt_oh;
   int                     idx;

   logic [UUID_BITS-1:0]   sel_uuid;
   logic [NW_BITS-1:0]     sel_wid;
   logic [NUM_THREADS-1:0] sel_tmask;
   logic [31:0]            sel_pc;
   logic [NR_BITS-1:0]     sel_rd;
   logic                   sel_wb;
   logic [DW-1:0]          sel_data;

   logic                   wb_valid_q, retire_valid_q;
   logic [UUID_BITS-1:0]   uuid_q;
   logic [NW_BITS-1:0]     wid_q;
   logic [NUM_THREADS-1:0] tmask_q;
   logic [31:0]            pc_q;
   logic [NR_BITS-1:0]     rd_q;
   logic [DW-1:0]          data_q;
   logic [63:0]            count_q;

   // Scan ptr, ptr+1, ... with wrap; first valid source wins.
   always_comb begin
      gnt    = 1'b0;
      gidx   = '0;
      gnt_oh = '0;
      idx    = 0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         idx = (int'(ptr_q) + k) % NUM_SRCS;
         if (!gnt && valid_in[idx]) begin
            gnt  = 1'b1;
            gidx = PW'(idx);
         end
      end
      if (reset) gnt = 1'b0;
      if (gnt) gnt_oh[gidx] = 1'b1;
   end

   assign ready_out = gnt_oh;
   assign ptr_d = (gidx == PW'(NUM_SRCS - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      sel_uuid  = uuid_in[gidx*UUID_BITS +: UUID_BITS];
      sel_wid   = wid_in[gidx*NW_BITS +: NW_BITS];
      sel_tmask = tmask_in[gidx*NUM_THREADS +: NUM_THREADS];
      sel_pc    = PC_in[gidx*32 +: 32];
      sel_rd    = rd_in[gidx*NR_BITS +: NR_BITS];
      sel_wb    = wb_in[gidx];
      sel_data  = data_in[gidx*DW +: DW];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q          <= '0;
         wb_valid_q     <= 1'b0;
         retire_valid_q <= 1'b0;
         uuid_q         <= '0;
         wid_q          <= '0;
         tmask_q        <= '0;
         pc_q           <= '0;
         rd_q           <= '0;
         data_q         <= '0;
         count_q        <= '0;
      end else begin
         wb_valid_q     <= gnt && sel_wb && (|sel_tmask);
         retire_valid_q <= gnt;
         if (gnt) begin
            ptr_q   <= ptr_d;
            uuid_q  <= sel_uuid;
            wid_q   <= sel_wid;
            tmask_q <= sel_tmask;
            pc_q    <= sel_pc;
            rd_q    <= sel_rd;
            data_q  <= sel_data;
         end
         // Count lags retire_valid by one cycle.
         if (retire_valid_q) count_q <= count_q + 64'd1;
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_uuid      = uuid_q;
   assign wb_wid       = wid_q;
   assign wb_tmask     = tmask_q;
   assign wb_PC        = pc_q;
   assign wb_rd        = rd_q;
   assign wb_data      = data_q;
   assign retire_valid = retire_valid_q;
   assign retire_wid   = wid_q;
   assign retire_count = count_q;

endmodule

// File: tb/tb_rv_writeback_arbiter.sv
// Scoreboard bench for rv_writeback_arbiter: source fields held in
// arrays, expected commits queued at accept and compared a cycle later.
module tb_rv_writeback_arbiter;

   localparam int NS = 3;
   localparam int NT = 4;
   localparam int NW = 2;
   localparam int NR = 5;
   localparam int UB = 44;
   localparam int DW = NT * 32;

   logic              clk;
   logic              reset;
   logic [NS-1:0]     valid_in;
   logic [NS*UB-1:0]  uuid_in;
   logic [NS*NW-1:0]  wid_in;
   logic [NS*NT-1:0]  tmask_in;
   logic [NS*32-1:0]  PC_in;
   logic [NS*NR-1:0]  rd_in;
   logic [NS-1:0]     wb_in;
   logic [NS*DW-1:0]  data_in;
   logic [NS-1:0]     ready_out;
   logic              wb_valid;
   logic [UB-1:0]     wb_uuid;
   logic [NW-1:0]     wb_wid;
   logic [NT-1:0]     wb_tmask;
   logic [31:0]       wb_PC;
   logic [NR-1:0]     wb_rd;
   logic [DW-1:0]     wb_data;
   logic              retire_valid;
   logic [NW-1:0]     retire_wid;
   logic [63:0]       retire_count;

   rv_writeback_arbiter dut (
      .clk(clk), .reset(reset), .valid_in(valid_in),
      .uuid_in(uuid_in), .wid_in(wid_in), .tmask_in(tmask_in),
      .PC_in(PC_in), .rd_in(rd_in), .wb_in(wb_in), .data_in(data_in),
      .ready_out(ready_out), .wb_valid(wb_valid), .wb_uuid(wb_uuid),
      .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_PC(wb_PC),
      .wb_rd(wb_rd), .wb_data(wb_data), .retire_valid(retire_valid),
      .retire_wid(retire_wid), .retire_count(retire_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [UB-1:0] s_uuid [NS];
   logic [NW-1:0] s_wid  [NS];
   logic [NT-1:0] s_tm   [NS];
   logic [31:0]   s_pc   [NS];
   logic [NR-1:0] s_rd   [NS];
   logic          s_wb   [NS];
   logic [DW-1:0] s_data [NS];

   always_comb begin
      uuid_in  = '0;
      wid_in   = '0;
      tmask_in = '0;
      PC_in    = '0;
      rd_in    = '0;
      wb_in    = '0;
      data_in  = '0;
      for (int i = 0; i < NS; i++) begin
         uuid_in[i*UB +: UB]  = s_uuid[i];
         wid_in[i*NW +: NW]   = s_wid[i];
         tmask_in[i*NT +: NT] = s_tm[i];
         PC_in[i*32 +: 32]    = s_pc[i];
         rd_in[i*NR +: NR]    = s_rd[i];
         wb_in[i]             = s_wb[i];
         data_in[i*DW +: DW]  = s_data[i];
      end
   end

   typedef struct {
      logic          ret;
      logic          wbv;
      logic [UB-1:0] uuid;
      logic [NW-1:0] wid;
      logic [NT-1:0] tm;
      logic [31:0]   pc;
      logic [NR-1:0] rd;
      logic [DW-1:0] data;
   } exp_t;

   exp_t   sb[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     m_ptr = 0;
   longint m_cnt = 0;
   int     last_g;
   int     uid_ctr = 1;
   logic [UB-1:0] tgt;
   int     hits = 0;
   int     grants[$];
   logic   rnd_mode = 1'b0;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh(input int i);
      s_uuid[i] = UB'(uid_ctr);
      uid_ctr++;
      s_wid[i]  = NW'($urandom);
      s_pc[i]   = $urandom;
      s_rd[i]   = NR'($urandom);
      s_data[i] = {$urandom, $urandom, $urandom, $urandom};
      if (rnd_mode) begin
         s_tm[i] = NT'($urandom_range(0, 15));
         s_wb[i] = ($urandom_range(0, 3) != 0);
      end else begin
         s_tm[i] = NT'($urandom_range(1, 15));
         s_wb[i] = 1'b1;
      end
   endtask

   // One clock: check last cycle's commit, drive valids, model grant.
   task automatic cycle(input logic [NS-1:0] v);
      exp_t e;
      int   g;
      logic [NS-1:0] er;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("retire_valid", retire_valid, e.ret);
         check("wb_valid", wb_valid, e.wbv);
         check("retire_count", retire_count, m_cnt);
         if (e.ret) begin
            check("wb_uuid", wb_uuid, e.uuid);
            check("wb_wid", wb_wid, e.wid);
            check("retire_wid", retire_wid, e.wid);
            check("wb_tmask", wb_tmask, e.tm);
            check("wb_PC", wb_PC, e.pc);
            check("wb_rd", wb_rd, e.rd);
            check("wb_data", wb_data, e.data);
            m_cnt++;
            if (wb_uuid == tgt) hits++;
         end
      end
      valid_in = v;
      #1;
      g = -1;
      if (!reset) begin
         for (int k = 0; k < NS; k++) begin
            int ix;
            ix = (m_ptr + k) % NS;
            if (g < 0 && v[ix]) g = ix;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("ready_out", ready_out, er);
      e = '{default: '0};
      if (g >= 0) begin
         e.ret  = 1'b1;
         e.wbv  = s_wb[g] && (s_tm[g] != 0);
         e.uuid = s_uuid[g];
         e.wid  = s_wid[g];
         e.tm   = s_tm[g];
         e.pc   = s_pc[g];
         e.rd   = s_rd[g];
         e.data = s_data[g];
         m_ptr  = (g + 1) % NS;
         grants.push_back(g);
      end
      if (reset) begin
         m_ptr = 0;
         m_cnt = 0;
      end
      sb.push_back(e);
      last_g = g;
      @(posedge clk);
      @(negedge clk);
      if (g >= 0) refresh(g);
   endtask

   initial begin
      int n2;
      tgt = '1;
      for (int i = 0; i < NS; i++) refresh(i);
      reset = 1'b1;
      valid_in = '0;

      cycle(3'b111);
      cycle(3'b111);
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_count", retire_count, 64'd0);
      check("rst_uuid", wb_uuid, '0);
      check("rst_data", wb_data, '0);
      reset = 1'b0;

      grants.delete();
      for (int c = 0; c < 6; c++) cycle(3'b111);
      for (int c = 0; c < 6; c++)
         check("fair_order", grants[c], c % 3);
      cycle(3'b000);
      check("fair_count", retire_count, 64'd6);

      cycle(3'b011);
      cycle(3'b010);
      cycle(3'b011);
      check("wrap_g0", last_g, 0);
      cycle(3'b011);
      check("wrap_g1", last_g, 1);

      s_wb[0] = 1'b0;
      s_rd[0] = 5'd5;
      s_tm[0] = 4'hF;
      cycle(3'b001);
      check("nowb_retire", retire_valid, 1'b1);
      check("nowb_wb", wb_valid, 1'b0);
      s_wb[0] = 1'b1;
      s_tm[0] = 4'h0;
      cycle(3'b001);
      check("notm_retire", retire_valid, 1'b1);
      check("notm_wb", wb_valid, 1'b0);

      s_wid[1]  = 2'd2;
      s_rd[1]   = 5'd7;
      s_pc[1]   = 32'h8000_0010;
      s_tm[1]   = 4'b1010;
      s_wb[1]   = 1'b1;
      s_data[1] = {32'h44, 32'h33, 32'h22, 32'h11};
      cycle(3'b010);
      check("dp_wb_valid", wb_valid, 1'b1);
      check("dp_wid", wb_wid, 2'd2);
      check("dp_rd", wb_rd, 5'd7);
      check("dp_pc", wb_PC, 32'h8000_0010);
      check("dp_tmask", wb_tmask, 4'b1010);
      check("dp_data", wb_data, {32'h44, 32'h33, 32'h22, 32'h11});
      cycle(3'b000);

      cycle(3'b001);
      tgt = s_uuid[2];
      hits = 0;
      n2 = 0;
      for (int c = 0; c < 3; c++) begin
         cycle(3'b111);
         if (last_g == 2) n2++;
      end
      cycle(3'b000);
      check("bp_grants", n2, 1);
      check("bp_commits", hits, 1);

      rnd_mode = 1'b1;
      for (int i = 0; i < NS; i++) refresh(i);
      for (int c = 0; c < 60; c++) cycle(NS'($urandom));
      cycle(3'b000);
      cycle(3'b000);
      check("final_count", retire_count, m_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_writeback_arbiter.md
# rv_writeback_arbiter

Commit-side consumer of execution-unit response streams (ALU, mul/div, LSU, CSR, ...). Arbitrates round-robin among NUM_SRCS valid/ready response channels carrying {uuid, wid, tmask, PC, rd, wb, data}, registers the winner and drives the GPR file write port plus a retire counter. It sits between the execute stage's per-unit output pipe registers and the register file / scoreboard release.

## Interface
- NUM_SRCS, 3: number of response channels; must be ≥ 2.
- NUM_THREADS, 4: lanes per warp.
- NW_BITS, 2: warp-id width.
- NR_BITS, 5: register-index width.
- UUID_BITS, 44: instruction uuid width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  NUM_SRCS  per-source response valid.
- uuid_in  in  NUM_SRCS*UUID_BITS  per-source uuid; source i occupies slice i.
- wid_in  in  NUM_SRCS*NW_BITS  per-source warp id.
- tmask_in  in  NUM_SRCS*NUM_THREADS  per-source thread mask.
- PC_in  in  NUM_SRCS*32  per-source PC.
- rd_in  in  NUM_SRCS*NR_BITS  per-source destination register.
- wb_in  in  NUM_SRCS  per-source writeback-enable.
- data_in  in  NUM_SRCS*NUM_THREADS*32  per-source lane results.
- ready_out  out  NUM_SRCS  per-source accept (one-hot or zero).
- wb_valid  out  1  register-file write strobe.
- wb_uuid, wb_wid, wb_PC, wb_rd  out  UUID_BITS / NW_BITS / 32 / NR_BITS  committed instruction fields.
- wb_tmask  out  NUM_THREADS  per-lane write enables.
- wb_data  out  NUM_THREADS*32  write data.
- retire_valid  out  1  one instruction retired this cycle (independent of wb).
- retire_wid  out  NW_BITS  warp of retired instruction.
- retire_count  out  64  total retired instructions since reset.

## Operation
- Handshake per source: transfer when valid_in[i] && ready_out[i]. Sources hold all fields stable while valid and not accepted.
- Register file never backpressures; exactly one transfer per cycle whenever any valid_in bit is set.
- Arbitration: round-robin pointer ptr (clog2(NUM_SRCS) bits). Grant = first i with valid_in[i] set scanning ptr, ptr+1, ..., wrapping modulo NUM_SRCS. ready_out = grant one-hot (combinational from valid_in and ptr); zero when no valid.
- After a grant to index g, ptr ← (g+1) mod NUM_SRCS; no grant → ptr unchanged. Wrap: g = NUM_SRCS-1 → ptr = 0.
- Output register captures granted fields every cycle a grant exists.
- wb_valid = registered (grant && wb_in[g] && tmask_in[g] != 0); wb_tmask = registered tmask_in[g].
- retire_valid = registered (grant exists), regardless of wb or tmask; retire_wid = registered wid.
- retire_count increments by 1 in the cycle retire_valid is registered high; wraps 2^64-1 → 0.
- When no grant: wb_valid and retire_valid go 0; data/field outputs hold last values (don't-care).

## Timing
- Accept at edge t (valid & ready sampled) → wb_*/retire_* valid after edge t, i.e. 1-cycle latency; retire_count reflects the new value one cycle after retire_valid is asserted.
- Throughput: one response per cycle aggregate; with all NUM_SRCS continuously valid each source receives exactly one grant every NUM_SRCS cycles.
- Reset (synchronous, takes priority over everything): ptr=0, wb_valid=0, retire_valid=0, retire_count=0, wb_uuid/wb_wid/wb_PC/wb_rd/wb_tmask/wb_data/retire_wid=0. ready_out is 0 while reset is high, so no source is accepted during reset; a response in flight mid-reset is neither written nor counted.
- Simultaneous new valid on the source just granted: excluded this round by pointer advance; granted later in rotation.
- Single requester: granted every cycle regardless of ptr.

## Test plan
- Reset: hold reset 2 cycles with valid_in=3'b111 → ready_out=0, wb_valid=0, retire_count=0; first cycle after reset grants source 0.
- Fairness: valid_in=3'b111 held 6 cycles → grant order 0,1,2,0,1,2; retire_count=6 one cycle after the last retire_valid.
- Wrap/skip: ptr=2, valid_in=3'b011 → grant source 0, ptr→1; next cycle grants source 1.
- Writeback suppression: single source with wb_in=0, rd=5, tmask=4'hF → retire_valid=1, wb_valid=0; with wb_in=1, tmask=0 → wb_valid=0, retire counted.
- Data path: source 1 sends wid=2, rd=7, PC=0x8000_0010, tmask=4'b1010, data lanes {0x11,0x22,0x33,0x44} → next cycle wb_valid=1 with identical fields, ready_out[1] held high only in the accept cycle.
- Backpressure hold: source 2 valid with sources 0,1 continuously valid → source 2 fields stay stable and are accepted within 3 cycles, committed exactly once.
